// File: rtl/mac_arbiter_pkg.sv
// Shared types and constants for the MAC arbiter and sequencer.
package mac_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        BUSY  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

    localparam int DEFAULT_NREQ    = 4;
    localparam int DEFAULT_LEN_W   = 8;
    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_TIMEOUT = 1024;

    // Width of an index into n items; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_IDX_W = idx_width(DEFAULT_NREQ);

endpackage

// File: rtl/mac_arbiter_if.sv
// Request/response and MAC control bundle between clients, arbiter and MAC.
// slave = arbiter side, master = client/MAC side.
interface mac_arbiter_if
    import mac_arbiter_pkg::*;
#(
    parameter int NREQ   = DEFAULT_NREQ,
    parameter int LEN_W  = DEFAULT_LEN_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_err;
    logic                  mac_go;
    logic [LEN_W-1:0]      mac_len;
    logic                  mac_done;
    logic [DATA_W-1:0]     mac_result;
    logic                  mac_abort;

    modport slave (
        input  req, req_len, mac_done, mac_result,
        output gnt, rsp_valid, rsp_data, rsp_err, mac_go, mac_len, mac_abort
    );

    modport master (
        output req, req_len, mac_done, mac_result,
        input  gnt, rsp_valid, rsp_data, rsp_err, mac_go, mac_len, mac_abort
    );
endinterface

// File: rtl/mac_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the first set request after
// ptr (wrapping modulo NREQ) wins, so ptr itself has the lowest priority.
module rr_pick
    import mac_arbiter_pkg::*;
#(
    parameter int NREQ  = DEFAULT_NREQ,
    parameter int IDX_W = DEFAULT_IDX_W
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);
    logic [IDX_W-1:0] idx;

    // Scan from lowest to highest priority so the nearest set bit after ptr is the last write
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IDX_W'((int'(ptr) + i) % NREQ);
            if (req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter/sequencer sharing one MAC among NREQ requesters.
//
// state | meaning
// IDLE  | no operation; arbitrate among pending requests
// ISSUE | grant shown, mac_go pulsed (or zero-length shortcut to RESP)
// BUSY  | waiting for mac_done, watchdog running
// RESP  | rsp_valid strobe to the winner, pointer rotates
module mac_arbiter
    import mac_arbiter_pkg::*;
#(
    parameter int NREQ    = DEFAULT_NREQ,
    parameter int LEN_W   = DEFAULT_LEN_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    mac_arbiter_if.slave  bus
);
    localparam int IDX_W = idx_width(NREQ);
    localparam int WD_W  = idx_width(TIMEOUT);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [WD_W-1:0]  wd;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [LEN_W-1:0] pick_len;
    logic [NREQ-1:0]  pick_oh;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (pick_idx),
        .any    (pick_any)
    );

    // Decode the winner index into a one-hot grant and select its length slice
    always_comb begin
        pick_len = '0;
        pick_oh  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_any && pick_idx == IDX_W'(i)) begin
                pick_len   = bus.req_len[i*LEN_W +: LEN_W];
                pick_oh[i] = 1'b1;
            end
        end
    end

    // Sequencer FSM; all outputs registered. On timeout the abort pulse
    // coincides with the error response, since a same-cycle mac_done must
    // be able to cancel it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= IDX_W'(NREQ - 1);
            win_idx       <= '0;
            wd            <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.mac_go    <= 1'b0;
            bus.mac_len   <= '0;
            bus.mac_abort <= 1'b0;
        end else begin
            bus.mac_go    <= 1'b0;
            bus.mac_abort <= 1'b0;
            bus.rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        win_idx     <= pick_idx;
                        bus.mac_len <= pick_len;
                        bus.gnt     <= pick_oh;
                        bus.mac_go  <= (pick_len != '0);
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd <= '0;
                    if (bus.mac_len != '0) begin
                        state <= BUSY;
                    end else begin
                        bus.rsp_valid <= bus.gnt;
                        bus.rsp_data  <= DATA_W'(0);
                        bus.rsp_err   <= 1'b0;
                        state         <= RESP;
                    end
                end
                BUSY: begin
                    wd <= wd + WD_W'(1);
                    if (bus.mac_done) begin
                        bus.rsp_valid <= bus.gnt;
                        bus.rsp_data  <= bus.mac_result;
                        bus.rsp_err   <= 1'b0;
                        state         <= RESP;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        bus.mac_abort <= 1'b1;
                        bus.rsp_valid <= bus.gnt;
                        bus.rsp_data  <= DATA_W'(0);
                        bus.rsp_err   <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    ptr     <= win_idx;
                    bus.gnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_arbiter.sv
// Self-checking bench for mac_arbiter: directed vector table, multi-cycle
// sequences (fairness, mid-operation reset) and randomized operations
// checked against a transaction-level reference model.
module tb_mac_arbiter;
    localparam int NREQ    = 4;
    localparam int LEN_W   = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   last_win;

    mac_arbiter_if #(.NREQ(NREQ), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

    mac_arbiter #(
        .NREQ    (NREQ),
        .LEN_W   (LEN_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]       rq;
        logic [NREQ*LEN_W-1:0] lens;
        int                    delay;   // BUSY cycle (1-based) in which mac_done is driven
        logic [DATA_W-1:0]     res;
        logic                  stray;   // mac_done pulses during ISSUE and RESP
        logic                  drop;    // winner drops req after its response
        logic [NREQ-1:0]       e_gnt;
        logic [LEN_W-1:0]      e_len;
        logic                  e_go;
        int                    e_n;     // cycles from ISSUE to rsp_valid
        logic [DATA_W-1:0]     e_data;
        logic                  e_err;
        logic                  e_abort;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the first requester after the last winner, wrapping around
    function automatic int rr_next(input logic [NREQ-1:0] rq, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (rq[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference: expected outcome of one operation from length and MAC delay
    function automatic vec_t model(input vec_t v, input int w);
        vec_t r = v;
        r.e_gnt = NREQ'(1) << w;
        r.e_len = v.lens[w*LEN_W +: LEN_W];
        r.e_go  = (r.e_len != '0);
        if (!r.e_go) begin
            r.e_n = 1; r.e_data = '0; r.e_err = 1'b0; r.e_abort = 1'b0;
        end else if (v.delay <= TIMEOUT) begin
            r.e_n = v.delay + 1; r.e_data = v.res; r.e_err = 1'b0; r.e_abort = 1'b0;
        end else begin
            r.e_n = TIMEOUT + 1; r.e_data = '0; r.e_err = 1'b1; r.e_abort = 1'b1;
        end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0; bus.req_len = '0; bus.mac_done = 1'b0; bus.mac_result = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One operation; called at a negedge while the DUT is in IDLE
    task automatic run_op(input vec_t v, input bit scramble, output logic [NREQ-1:0] obs_gnt);
        int n;
        bit got;
        bus.req = v.rq; bus.req_len = v.lens; bus.mac_done = 1'b0;
        @(negedge clk);
        obs_gnt = bus.gnt;
        chk("gnt_issue", bus.gnt, v.e_gnt);
        chk("mac_go", bus.mac_go, v.e_go);
        chk("mac_len", bus.mac_len, v.e_len);
        chk("abort_issue", bus.mac_abort, 0);
        chk("rsp_issue", bus.rsp_valid, 0);
        if (scramble) begin
            bus.req_len = $urandom;
            if ($urandom_range(0, 1) == 1) bus.req = bus.req & ~v.e_gnt;
        end
        bus.mac_done = v.stray; bus.mac_result = $urandom;
        n = 0; got = 0;
        while (!got && n <= TIMEOUT + 4) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid != '0) begin
                got = 1;
                chk("rsp_cycle", n, v.e_n);
                chk("rsp_valid", bus.rsp_valid, v.e_gnt);
                chk("rsp_data", bus.rsp_data, v.e_data);
                chk("rsp_err", bus.rsp_err, v.e_err);
                chk("mac_abort", bus.mac_abort, v.e_abort);
                chk("gnt_resp", bus.gnt, v.e_gnt);
                chk("go_resp", bus.mac_go, 0);
                bus.mac_done = v.stray; bus.mac_result = $urandom;
                if (v.drop) bus.req = bus.req & ~v.e_gnt;
            end else begin
                chk("gnt_hold", bus.gnt, v.e_gnt);
                chk("go_pulse", bus.mac_go, 0);
                chk("abort_early", bus.mac_abort, 0);
                bus.mac_done   = v.e_go && (n == v.delay);
                bus.mac_result = bus.mac_done ? v.res : $urandom;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL rsp_seen: no rsp_valid within %0d cycles", TIMEOUT + 5);
        end
        @(negedge clk);
        chk("gnt_drop", bus.gnt, 0);
        chk("rsp_after", bus.rsp_valid, 0);
        chk("abort_after", bus.mac_abort, 0);
        chk("rsp_data_hold", bus.rsp_data, v.e_data);
        chk("rsp_err_hold", bus.rsp_err, v.e_err);
        bus.mac_done = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tab[7];
        vec_t v;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] seen;
        int w;

        //            rq       lens          dly  res           st    dr    gnt      len    go   n   data          err   abort
        tab[0] = '{4'b0100, 32'h0003_0000,   6, 32'h0000_1234, 1'b0, 1'b1, 4'b0100, 8'd3, 1'b1,  7, 32'h0000_1234, 1'b0, 1'b0};
        tab[1] = '{4'b0010, 32'h0909_0009,   3, 32'h0000_0BAD, 1'b1, 1'b1, 4'b0010, 8'd0, 1'b0,  1, 32'h0000_0000, 1'b0, 1'b0};
        tab[2] = '{4'b0001, 32'h0000_0005, 100, 32'h0000_DEAD, 1'b0, 1'b1, 4'b0001, 8'd5, 1'b1, 17, 32'h0000_0000, 1'b1, 1'b1};
        tab[3] = '{4'b1000, 32'h0200_0000,   2, 32'hCAFE_F00D, 1'b0, 1'b1, 4'b1000, 8'd2, 1'b1,  3, 32'hCAFE_F00D, 1'b0, 1'b0};
        tab[4] = '{4'b0100, 32'h0001_0000,  16, 32'hA5A5_0001, 1'b0, 1'b1, 4'b0100, 8'd1, 1'b1, 17, 32'hA5A5_0001, 1'b0, 1'b0};
        tab[5] = '{4'b0110, 32'h0011_0700,   1, 32'h0000_0055, 1'b0, 1'b1, 4'b0010, 8'd7, 1'b1,  2, 32'h0000_0055, 1'b0, 1'b0};
        tab[6] = '{4'b1111, 32'h0403_0201,   3, 32'h0000_0077, 1'b1, 1'b1, 4'b0100, 8'd3, 1'b1,  4, 32'h0000_0077, 1'b0, 1'b0};

        do_reset();
        chk("reset_gnt", bus.gnt, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_data", bus.rsp_data, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);
        chk("reset_mac_go", bus.mac_go, 0);
        chk("reset_mac_len", bus.mac_len, 0);
        chk("reset_mac_abort", bus.mac_abort, 0);

        for (int i = 0; i < 7; i++) run_op(tab[i], 1'b0, g);

        // Fairness: all requesters held, grants must rotate 0,1,2,3,0
        do_reset();
        seen = '0;
        for (int k = 0; k < 5; k++) begin
            v = '{4'b1111, 32'h0101_0101, 2, 32'h100 + k, 1'b0, 1'b0,
                  NREQ'(1) << (k % NREQ), 8'd1, 1'b1, 3, 32'h100 + k, 1'b0, 1'b0};
            run_op(v, 1'b0, g);
            if (k < NREQ) seen = seen | g;
            if (k == NREQ - 1) chk("fair_all_served", seen, 4'hF);
        end

        // Reset in BUSY with requester 3 granted; pointer must return to NREQ-1
        bus.req = 4'b1000; bus.req_len = 32'h0900_0000; bus.mac_done = 1'b0;
        @(negedge clk);
        chk("rst_seq_gnt", bus.gnt, 4'b1000);
        chk("rst_seq_go", bus.mac_go, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_gnt", bus.gnt, 0);
        chk("rst_mid_go", bus.mac_go, 0);
        chk("rst_mid_rsp", bus.rsp_valid, 0);
        chk("rst_mid_abort", bus.mac_abort, 0);
        chk("rst_mid_len", bus.mac_len, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        v = '{4'b1001, 32'h0500_0004, 4, 32'h0000_BEEF, 1'b0, 1'b1, 4'b0001, 8'd4, 1'b1, 5, 32'h0000_BEEF, 1'b0, 1'b0};
        run_op(v, 1'b0, g);

        // Randomized operations against the reference model
        do_reset();
        last_win = NREQ - 1;
        for (int t = 0; t < 40; t++) begin
            v.rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++)
                v.lens[i*LEN_W +: LEN_W] = ($urandom_range(0, 3) == 0) ? '0 : LEN_W'($urandom_range(1, 255));
            v.delay = $urandom_range(1, TIMEOUT + 3);
            v.res   = $urandom;
            v.stray = 1'($urandom_range(0, 1));
            v.drop  = 1'b1;
            w = rr_next(v.rq, last_win);
            v = model(v, w);
            run_op(v, 1'b1, g);
            last_win = w;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_arbiter.md
Name: mac_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one MAC datapath among NREQ requesters.
- Accepts per-requester requests carrying a MAC length, and grants one requester at a time.
- Launches the shared MAC with a one-cycle go pulse, then waits for its done, with a watchdog timeout.
- Returns the result to the granted requester with a one-cycle response strobe. Sits between the client blocks and the existing MAC control/datapath pair.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LEN_W, 8, width of the per-request MAC length (number of accumulate iterations).
- DATA_W, 32, MAC result width.
- TIMEOUT, 1024, max BUSY cycles before abort (>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req  in  NREQ  per-requester request level.
- req_len  in  NREQ*LEN_W  packed lengths; slice i belongs to req[i].
- gnt  out  NREQ  one-hot grant.
- rsp_valid  out  NREQ  one-hot, 1-cycle response strobe.
- rsp_data  out  DATA_W  result, shared by all requesters.
- rsp_err  out  1  response is a timeout abort; qualified by rsp_valid.
- mac_go  out  1  1-cycle start pulse to the MAC.
- mac_len  out  LEN_W  latched length for the MAC.
- mac_done  in  1  MAC completion pulse.
- mac_result  in  DATA_W  MAC output; valid with mac_done.
- mac_abort  out  1  1-cycle abort pulse to the MAC on timeout.

Behaviour:
- Reset is asynchronous, active-high on rst; clock is clk (rising edge).
- Reset values:
  - All outputs 0.
  - State is IDLE.
  - Priority pointer ptr = NREQ-1, so requester 0 wins first.
  - Watchdog count is 0.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If any req bit is set, select a winner by searching from ptr+1 upward with modulo-NREQ wrap.
  - Register the winner index and its req_len slice; go to ISSUE. Otherwise stay in IDLE.
- ISSUE (one cycle):
  - gnt[winner]=1 and mac_len=latched length.
  - If length != 0: mac_go=1, clear the watchdog, go to BUSY.
  - If length == 0: no mac_go; set the result to 0 with err=0 and go to RESP.
- BUSY:
  - gnt is held and the watchdog increments every cycle.
  - mac_done is sampled only in BUSY. When it is set, latch mac_result with err=0 and go to RESP.
  - If the watchdog reaches TIMEOUT-1 without mac_done: mac_abort=1 for that cycle, result=0, err=1, go to RESP.
  - If mac_done and timeout occur in the same cycle, mac_done wins; no abort is issued.
- RESP (one cycle):
  - rsp_valid[winner]=1, rsp_data and rsp_err driven, gnt still held.
  - Set ptr=winner and go to IDLE. gnt drops on the next cycle.
  - rsp_data and rsp_err hold their values until the next RESP.
- Latency:
  - req seen in IDLE at cycle 0 → gnt and mac_go at cycle 1.
  - mac_done at cycle k → rsp_valid at cycle k+1.
  - gnt is 0 at cycle k+2.
  - Minimum length-0 turnaround: rsp_valid at cycle 2.
- Request rules:
  - Requests are levels. A requester drops req in the cycle after its rsp_valid.
  - A held req re-arbitrates fairly, because ptr has rotated past it.
  - If a requester drops req while granted, it is ignored: the operation completes and the response is still delivered.
  - req_len is sampled only in IDLE; later changes have no effect on the current operation.
- Stray mac_done pulses in IDLE, ISSUE or RESP are ignored.
- Reset mid-operation returns the block to reset values at once. No abort pulse is generated; the MAC is reset by the same rst.
- Invariants:
  - gnt is one-hot or zero.
  - rsp_valid is a subset of gnt.
  - mac_go and mac_abort are never both high.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'b00, ISSUE=2'b01, BUSY=2'b10, RESP=2'b11);
  - the default TIMEOUT;
  - the clog2-based index-width constant.
- One sub-module: rr_pick, a combinational round-robin priority encoder.
  - Inputs: req, ptr.
  - Outputs: winner index and an any-valid flag.
  - Reusable by future shared-resource arbiters.

Test Plan:
- Single requester: req[2]=1, len=3, mac_done 6 cycles after mac_go with result 0x1234 → gnt=4'b0100 at cycle 1, mac_go pulse with mac_len=3, rsp_valid=4'b0100 with rsp_data=0x1234 and rsp_err=0 one cycle after done.
- Fairness: req=4'b1111 held, each op done after 2 cycles → grant order 0,1,2,3,0; no requester is granted twice before all others are served.
- Zero length: req[1]=1, len=0 → no mac_go; rsp_valid[1] at cycle 2 with rsp_data=0 and rsp_err=0.
- Timeout: TIMEOUT=16 and mac_done never asserted → mac_abort pulse on the 16th BUSY cycle, then rsp_valid with rsp_err=1 and rsp_data=0; the next request is served normally.
- Simultaneous done and timeout: mac_done on the final watchdog cycle → no mac_abort; rsp_err=0 and the result is delivered.
- Reset mid-BUSY: assert rst during BUSY with req[3] active → gnt, mac_go and rsp_valid go to 0 immediately; after release, requester 0 wins when req=4'b1001.
